// File: rtl/brick_pkg.sv
// Brick field geometry, initial hit points per row, bounce codes and controller states.
`include "define.sv"
package brick_pkg;
  localparam int COLS      = 8;
  localparam int ROWS      = 4;
  localparam int CELLS     = COLS * ROWS;
  localparam int CELL_W    = 64;
  localparam int CELL_H    = 16;
  localparam int FIELD_X0  = 64;
  localparam int FIELD_Y0  = 32;
  localparam int FIELD_X1  = FIELD_X0 + COLS * CELL_W;
  localparam int FIELD_Y1  = FIELD_Y0 + ROWS * CELL_H;
  localparam int PX_W      = `PIXELX_BIT_CNT + 1;
  localparam int PY_W      = `PIXELY_BIT_CNT + 1;
  localparam int SIZE_W    = `BALL_SIZE_BIT_CNT;
  localparam int DIR_W     = `DIR_BIT_CNT;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 6;

  localparam logic [DIR_W-1:0] DIR_NONE    = DIR_W'(0);
  localparam logic [DIR_W-1:0] DIR_FLIP_Y  = DIR_W'(1);
  localparam logic [DIR_W-1:0] DIR_FLIP_X  = DIR_W'(2);
  localparam logic [DIR_W-1:0] DIR_FLIP_XY = DIR_W'(3);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PROBE_V, ST_PROBE_H, ST_PROBE_D, ST_RESP, ST_WAIT_LOW
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } cell_t;

  function automatic logic [1:0] init_hp(input int row);
    case (row)
      0:       return 2'd3;
      1:       return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [CELLS-1:0][1:0] init_map();
    logic [CELLS-1:0][1:0] m;
    for (int i = 0; i < CELLS; i++) m[i] = init_hp(i / COLS);
    return m;
  endfunction

  localparam logic [CELLS-1:0][1:0] INIT_MAP = init_map();

  // Coordinates carry a sign bit in their MSB; a negative probe lands outside the field.
  function automatic cell_t cell_at(input logic [PX_W-1:0] x, input logic [PY_W-1:0] y);
    cell_t c;
    c.vld = !x[PX_W-1] && !y[PY_W-1] &&
            (x >= PX_W'(FIELD_X0)) && (x < PX_W'(FIELD_X1)) &&
            (y >= PY_W'(FIELD_Y0)) && (y < PY_W'(FIELD_Y1));
    c.idx = {2'((y - PY_W'(FIELD_Y0)) / PY_W'(CELL_H)),
             3'((x - PX_W'(FIELD_X0)) / PX_W'(CELL_W))};
    return c;
  endfunction

  function automatic logic [1:0] apply_dmg(input logic [1:0] hp, input logic [1:0] dmg);
    logic [1:0] d;
    d = (dmg == 2'd0) ? 2'd1 : dmg;
    return (hp > d) ? hp - d : 2'd0;
  endfunction
endpackage

// File: rtl/brick_map.sv
// Hit-point store for the 32 cells: combinational read, single write, bulk reload and live count.
// Reload has priority over a same-cycle write.
module brick_map
  import brick_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_hp,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_hp,
  output logic [CNT_W-1:0] bricks_left
);
  logic [CELLS-1:0][1:0] hp_q, hp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    hp_d  = hp_q;
    cnt_d = cnt_q;
    if (reload) begin
      hp_d  = INIT_MAP;
      cnt_d = CNT_W'(CELLS);
    end else if (wr_en) begin
      hp_d[wr_idx] = wr_hp;
      if ((hp_q[wr_idx] != 2'd0) && (wr_hp == 2'd0)) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q  <= INIT_MAP;
      cnt_q <= CNT_W'(CELLS);
    end else begin
      hp_q  <= hp_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_hp       = hp_q[rd_idx];
  assign bricks_left = cnt_q;
endmodule

// File: rtl/define.sv
// Shared pixel, ball-size and bounce-code widths for the playfield blocks.
`ifndef BRICK_DEFINE_SV
`define BRICK_DEFINE_SV
`define PIXELX_BIT_CNT 10
`define PIXELY_BIT_CNT 9
`define BALL_SIZE_BIT_CNT 4
`define DIR_BIT_CNT 2
`endif

// File: rtl/brick_field.sv
// Ball/brick collision engine: V, H, D probes one per cycle, ack in the 4th cycle after req is sampled; req must drop before the next transaction.
// Optional BRICK_GADGET_EN adds an LFSR-gated gadget spawn pulse alongside ack.
`include "define.sv"
module brick_field
  import brick_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_game_start,
  input  logic [`PIXELX_BIT_CNT-1:0]    i_br_ballX,
  input  logic [`PIXELY_BIT_CNT-1:0]    i_br_ballY,
  input  logic [`BALL_SIZE_BIT_CNT-1:0] i_br_ball_size,
  input  logic [1:0]                    i_br_speedX,
  input  logic [1:0]                    i_br_speedY,
  input  logic [1:0]                    i_br_damage,
  input  logic                          i_brick_req,
  output logic                          o_brick_ack,
  output logic                          o_ball_brick_collision,
  output logic [`DIR_BIT_CNT-1:0]       o_direc_var,
  output logic                          o_br_gadget_gen,
  output logic [5:0]                    o_bricks_left,
  output logic                          o_stage_clear
);
  state_t                     state_q, state_d;
  logic [`PIXELX_BIT_CNT-1:0] bx_q, bx_d;
  logic [`PIXELY_BIT_CNT-1:0] by_q, by_d;
  logic [SIZE_W-1:0]          sz_q, sz_d;
  logic [1:0]                 sx_q, sx_d, sy_q, sy_d, dmg_q, dmg_d;
  logic                       v_hit_q, v_hit_d, h_hit_q, h_hit_d, coll_q, coll_d;
  logic [IDX_W-1:0]           v_idx_q, v_idx_d;
  logic [DIR_W-1:0]           dir_q, dir_d;

  logic [PX_W-1:0]  bx_ext, px;
  logic [PY_W-1:0]  by_ext, py;
  logic             sx_nz, sy_nz;
  cell_t            v_cell, h_cell, d_cell;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_hp, wr_hp;
  logic             wr_en, ack, same_cell, probe_hit;
  logic [CNT_W-1:0] bricks_left;

  assign bx_ext = {1'b0, bx_q};
  assign by_ext = {1'b0, by_q};
  assign sx_nz  = (sx_q == 2'b01) || (sx_q == 2'b11);
  assign sy_nz  = (sy_q == 2'b01) || (sy_q == 2'b11);

  always_comb begin
    unique case (sx_q)
      2'b01:   px = bx_ext + PX_W'(sz_q);
      2'b11:   px = bx_ext - PX_W'(sz_q);
      default: px = bx_ext;
    endcase
    unique case (sy_q)
      2'b01:   py = by_ext + PY_W'(sz_q);
      2'b11:   py = by_ext - PY_W'(sz_q);
      default: py = by_ext;
    endcase
  end

  assign v_cell = cell_at(bx_ext, py);
  assign h_cell = cell_at(px, by_ext);
  assign d_cell = cell_at(px, py);
  assign wr_hp  = apply_dmg(rd_hp, dmg_q);

  brick_map u_map (
    .clk         (clk),
    .rst_n       (rst_n),
    .reload      (i_game_start),
    .wr_en       (wr_en),
    .wr_idx      (rd_idx),
    .wr_hp       (wr_hp),
    .rd_idx      (rd_idx),
    .rd_hp       (rd_hp),
    .bricks_left (bricks_left)
  );

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    sz_d      = sz_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dmg_d     = dmg_q;
    v_hit_d   = v_hit_q;
    h_hit_d   = h_hit_q;
    v_idx_d   = v_idx_q;
    coll_d    = coll_q;
    dir_d     = dir_q;
    rd_idx    = v_cell.idx;
    wr_en     = 1'b0;
    ack       = 1'b0;
    same_cell = 1'b0;
    probe_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_brick_req) begin
          bx_d    = i_br_ballX;
          by_d    = i_br_ballY;
          sz_d    = i_br_ball_size;
          sx_d    = i_br_speedX;
          sy_d    = i_br_speedY;
          dmg_d   = i_br_damage;
          v_hit_d = 1'b0;
          h_hit_d = 1'b0;
          state_d = ST_PROBE_V;
        end
      end
      ST_PROBE_V: begin
        rd_idx    = v_cell.idx;
        probe_hit = sy_nz && v_cell.vld && (rd_hp != 2'd0);
        wr_en     = probe_hit;
        v_hit_d   = probe_hit;
        v_idx_d   = v_cell.idx;
        state_d   = ST_PROBE_H;
      end
      ST_PROBE_H: begin
        // A cell already damaged by the V probe counts as hit but is not damaged twice.
        rd_idx    = h_cell.idx;
        same_cell = v_hit_q && (h_cell.idx == v_idx_q);
        probe_hit = sx_nz && h_cell.vld && (same_cell || (rd_hp != 2'd0));
        wr_en     = probe_hit && !same_cell;
        h_hit_d   = probe_hit;
        state_d   = ST_PROBE_D;
      end
      ST_PROBE_D: begin
        rd_idx    = d_cell.idx;
        probe_hit = sx_nz && sy_nz && d_cell.vld && (rd_hp != 2'd0);
        wr_en     = probe_hit && !v_hit_q && !h_hit_q;
        coll_d    = v_hit_q || h_hit_q || probe_hit;
        if (v_hit_q && h_hit_q) dir_d = DIR_FLIP_XY;
        else if (v_hit_q)       dir_d = DIR_FLIP_Y;
        else if (h_hit_q)       dir_d = DIR_FLIP_X;
        else if (probe_hit)     dir_d = DIR_FLIP_XY;
        else                    dir_d = DIR_NONE;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        ack     = 1'b1;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!i_brick_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A restart abandons the transaction; outputs keep their last reported values.
    if (i_game_start) begin
      state_d = ST_WAIT_LOW;
      wr_en   = 1'b0;
      ack     = 1'b0;
      coll_d  = coll_q;
      dir_d   = dir_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      sz_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      dmg_q   <= '0;
      v_hit_q <= 1'b0;
      h_hit_q <= 1'b0;
      v_idx_q <= '0;
      coll_q  <= 1'b0;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      sz_q    <= sz_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      dmg_q   <= dmg_d;
      v_hit_q <= v_hit_d;
      h_hit_q <= h_hit_d;
      v_idx_q <= v_idx_d;
      coll_q  <= coll_d;
      dir_q   <= dir_d;
    end
  end

`ifdef BRICK_GADGET_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       destroyed_q, destroyed_d;

  always_comb begin
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    destroyed_d = destroyed_q;
    if (state_q == ST_IDLE)             destroyed_d = 1'b0;
    else if (wr_en && (wr_hp == 2'd0)) destroyed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= 8'hA5;
      destroyed_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      destroyed_q <= destroyed_d;
    end
  end

  assign o_br_gadget_gen = ack && destroyed_q && (lfsr_q[1:0] == 2'b00);
`else
  assign o_br_gadget_gen = 1'b0;
`endif

  assign o_brick_ack            = ack;
  assign o_ball_brick_collision = coll_q;
  assign o_direc_var            = dir_q;
  assign o_bricks_left          = bricks_left;
  assign o_stage_clear          = (bricks_left == '0);
endmodule

// File: tb/tb_brick_field.sv
// Randomised and directed transactions scored against a cell-array model of the brick field.
module tb_brick_field;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_game_start = 1'b0;
  logic [9:0] i_br_ballX = '0;
  logic [8:0] i_br_ballY = '0;
  logic [3:0] i_br_ball_size = '0;
  logic [1:0] i_br_speedX = '0;
  logic [1:0] i_br_speedY = '0;
  logic [1:0] i_br_damage = '0;
  logic       i_brick_req = 1'b0;
  logic       o_brick_ack, o_ball_brick_collision, o_br_gadget_gen, o_stage_clear;
  logic [1:0] o_direc_var;
  logic [5:0] o_bricks_left;

  brick_field dut (
    .clk(clk), .rst_n(rst_n), .i_game_start(i_game_start),
    .i_br_ballX(i_br_ballX), .i_br_ballY(i_br_ballY), .i_br_ball_size(i_br_ball_size),
    .i_br_speedX(i_br_speedX), .i_br_speedY(i_br_speedY), .i_br_damage(i_br_damage),
    .i_brick_req(i_brick_req), .o_brick_ack(o_brick_ack),
    .o_ball_brick_collision(o_ball_brick_collision), .o_direc_var(o_direc_var),
    .o_br_gadget_gen(o_br_gadget_gen), .o_bricks_left(o_bricks_left),
    .o_stage_clear(o_stage_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       coll;
    logic [1:0] dir;
    int         left;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int mhp[32];
  int mleft;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int spd(input logic [1:0] s);
    if (s == 2'b01) return 1;
    if (s == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int cell_of(input int x, input int y);
    if (x < 64 || x > 575 || y < 32 || y > 95) return -1;
    return ((y - 32) / 16) * 8 + (x - 64) / 64;
  endfunction

  task automatic model_reload();
    for (int i = 0; i < 32; i++) mhp[i] = (i < 8) ? 3 : (i < 16) ? 2 : 1;
    mleft = 32;
  endtask

  task automatic model_txn(input int bx, input int by, input int sz,
                           input logic [1:0] sxc, input logic [1:0] syc,
                           input logic [1:0] dmgc, output exp_t e);
    int sx, sy, d, px, py, cv, ch, cd;
    bit vh, hh, dh;
    int hits[$];
    sx = spd(sxc);
    sy = spd(syc);
    d  = (dmgc == 2'd0) ? 1 : int'(dmgc);
    px = bx + sx * sz;
    py = by + sy * sz;
    cv = (sy != 0) ? cell_of(bx, py) : -1;
    ch = (sx != 0) ? cell_of(px, by) : -1;
    cd = (sx != 0 && sy != 0) ? cell_of(px, py) : -1;
    vh = (cv >= 0) ? (mhp[cv] > 0) : 1'b0;
    hh = (ch >= 0) ? (mhp[ch] > 0) : 1'b0;
    dh = (cd >= 0) ? (mhp[cd] > 0) : 1'b0;
    if (vh) hits.push_back(cv);
    if (hh && !(vh && ch == cv)) hits.push_back(ch);
    if (!vh && !hh && dh) hits.push_back(cd);
    foreach (hits[k]) begin
      mhp[hits[k]] = (mhp[hits[k]] > d) ? mhp[hits[k]] - d : 0;
      if (mhp[hits[k]] == 0) mleft--;
    end
    e.coll = vh || hh || dh;
    e.dir  = (vh && hh) ? 2'd3 : vh ? 2'd1 : hh ? 2'd2 : dh ? 2'd3 : 2'd0;
    e.left = mleft;
    e.cyc  = 0;
  endtask

  // Scoreboard: every ack consumes one expected response.
  always @(posedge clk) begin
    #1;
    if (o_brick_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: ack=1 at cycle %0d, expected no ack", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("collision", o_ball_brick_collision, e.coll);
        check("direction", o_direc_var, e.dir);
        check("bricks_left", o_bricks_left, e.left);
        check("stage_clear", o_stage_clear, (e.left == 0) ? 1 : 0);
        check("gadget_gen", o_br_gadget_gen, 0);
      end
    end
  end

  task automatic run_txn(input int bx, input int by, input int sz,
                         input logic [1:0] sx, input logic [1:0] sy,
                         input logic [1:0] dmg, input int hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    i_br_ballX     = 10'(bx);
    i_br_ballY     = 9'(by);
    i_br_ball_size = 4'(sz);
    i_br_speedX    = sx;
    i_br_speedY    = sy;
    i_br_damage    = dmg;
    i_brick_req    = 1'b1;
    model_txn(bx, by, sz, sx, sy, dmg, e);
    // Sampling edge lands at cyc+1; ack fills the 4th cycle after it.
    e.cyc = cyc + 4;
    exp_q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_brick_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout: no ack within 20 cycles, expected one");
      void'(exp_q.pop_back());
    end
    repeat (hold) @(negedge clk);
    i_brick_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_game_start = 1'b1;
    model_reload();
    @(negedge clk);
    i_game_start = 1'b0;
    check("reload_left", o_bricks_left, mleft);
    check("reload_clear", o_stage_clear, 0);
  endtask

  task automatic abort_txn(input bit by_reset);
    @(negedge clk);
    i_br_ballX     = 10'd288;
    i_br_ballY     = 9'd50;
    i_br_ball_size = 4'd4;
    i_br_speedX    = 2'b00;
    i_br_speedY    = 2'b11;
    i_br_damage    = 2'd3;
    i_brick_req    = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_dip", o_bricks_left, mleft - ((mhp[3] > 0) ? 1 : 0));
    if (by_reset) begin
      rst_n       = 1'b0;
      i_brick_req = 1'b0;
    end else begin
      i_game_start = 1'b1;
    end
    @(negedge clk);
    i_game_start = 1'b0;
    rst_n        = 1'b1;
    model_reload();
    check("abort_left", o_bricks_left, mleft);
    check("abort_clear", o_stage_clear, 0);
    repeat (6) @(negedge clk);
    i_brick_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_left", o_bricks_left, 32);
    check("rst_clear", o_stage_clear, 0);
    check("rst_ack", o_brick_ack, 0);
    check("rst_coll", o_ball_brick_collision, 0);
    check("rst_dir", o_direc_var, 0);
    check("rst_gadget", o_br_gadget_gen, 0);
    rst_n = 1'b1;
    model_reload();
    @(negedge clk);

    run_txn(100, 99, 4, 2'b00, 2'b11, 2'd1, 0);   // vertical hit destroys row3/col0
    pulse_start();
    run_txn(60, 98, 4, 2'b01, 2'b11, 2'd1, 0);    // diagonal-only hit on row3/col0
    run_txn(100, 50, 4, 2'b00, 2'b11, 2'd1, 0);   // row0/col0 3->2
    run_txn(160, 50, 4, 2'b00, 2'b11, 2'd0, 0);   // damage 0 acts as 1
    run_txn(224, 50, 4, 2'b00, 2'b11, 2'd3, 0);   // 3->0
    run_txn(100, 50, 4, 2'b00, 2'b11, 2'd2, 20);  // req held: single ack
    abort_txn(1'b0);
    run_txn(288, 50, 4, 2'b00, 2'b11, 2'd2, 0);   // reloaded cell: 3->1
    abort_txn(1'b1);
    check("post_reset_coll", o_ball_brick_collision, 0);

    for (int n = 0; n < 150; n++) begin
      if (n % 50 == 49) pulse_start();
      run_txn($urandom_range(0, 640), $urandom_range(0, 120), $urandom_range(0, 15),
              2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 3));
    end

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        run_txn(96 + 64 * c, 44 + 16 * r, 4, 2'b00, 2'b11, 2'd3, 0);
    check("all_cleared_left", o_bricks_left, mleft);
    check("all_cleared_flag", o_stage_clear, (mleft == 0) ? 1 : 0);
    pulse_start();

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
